serial_tx: RTL and testbench
============================

# serial_tx

Asynchronous-serial frame transmitter: accepts a parallel word over a VALID/READY handshake and shifts it out on one line as start bit, data bits LSB-first, optional even parity bit, stop bit. It is the sending end of the team's single-wire serial link. It is written as synthesizable behavioural Verilog so it can be mapped onto the team's CMOS cell library (NOT, NAND_2/3, NOR_2/3, DFF) and simulated with back-annotated cell delays.

## Interface
- `WIDTH`, 8, data bits per frame (1..16)
- `DIV`, 4, clock cycles per serial bit (1..255)
- `PARITY`, 0, 0 = no parity bit, 1 = even parity bit after the data bits
- `C`  input  1  clock, all state changes on rising edge
- `R`  input  1  reset, asynchronous, active-high
- `DATA`  input  WIDTH  word to transmit, sampled on the accept edge only
- `VALID`  input  1  sender has a word on DATA
- `READY`  output  1  block can accept a word this cycle
- `TX`  output  1  serial line, idle high
- `BUSY`  output  1  a frame is in progress

## Operation
- Clock and reset: one clock `C`; reset `R` is asynchronous and active-high.
- Reset values (immediate on R high, held while high): TX=1, READY=1, BUSY=0, state IDLE, counters 0, shift register 0.
- Accept: a word is accepted on a rising edge of C with VALID=1 and READY=1. DATA is latched into the shift register, and the parity bit (XOR of DATA) is latched when PARITY=1. VALID while READY=0 is ignored, with no queueing.
- States:
  - IDLE: READY=1, BUSY=0, TX=1. On accept, go to START.
  - START: TX=0 for DIV cycles.
  - DATA: TX=shift register bit 0 for DIV cycles per bit, shifting right after each bit. WIDTH bits total, tracked by a bit counter 0..WIDTH-1.
  - PAR: entered only if PARITY=1. TX=latched parity for DIV cycles.
  - STOP: TX=1 for DIV cycles, then IDLE.
- READY=0 and BUSY=1 in every state except IDLE. Outputs are registered, with no combinational path from inputs to TX, READY or BUSY.
- Bit timer: a down-counter loaded with DIV-1 on each state or bit entry. A bit ends when it reaches 0. DIV=1 gives one cycle per bit, and the counter stays at 0.
- DATA changes after the accept edge do not affect the frame in flight.
- Reset mid-frame: the frame is abandoned, TX returns to 1 immediately, and there is no partial stop bit. After R falls the block is in IDLE with READY=1.

## Timing
- Accept at edge k. TX goes low after edge k (registered), and READY=0 after edge k.
- Frame length: (2 + WIDTH + PARITY) × DIV cycles, from TX falling to the end of the stop bit.
- READY returns high on the edge that ends STOP. The earliest next accept is that same cycle's following edge, so the minimum idle gap is DIV stop cycles plus 1 IDLE cycle. Back-to-back frames with VALID held high repeat every (2 + WIDTH + PARITY) × DIV + 1 cycles.
- Mapped-netlist target: 40 ns clock period under cell delays (DFF clock-to-Q 3.8 ns, setup 1.1 ns, hold 0.4 ns, gates ≤10 ns). Worst register-to-register path is at most 3 gate levels deep plus setup.
- No timing is derived from the reset release other than one clean IDLE cycle.

## Structure
- Shared include `serial_defs.vh` holds:
  - state encoding constants (`ST_IDLE`, `ST_START`, `ST_DATA`, `ST_PAR`, `ST_STOP`, 3-bit binary);
  - default `WIDTH` and `DIV` values, shared with the future receiver.
- One sub-module, `bit_timer`. It holds the DIV down-counter with a load input and an `end_of_bit` output, and is reused by the receiver.
- The top level `serial_tx` holds the FSM, shift register, bit counter, parity register and output registers.

## Test plan
- Reset idle: R=1 mid-simulation, then released. TX=1, READY=1 and BUSY=0 immediately, and TX stays 1 with VALID=0.
- Single frame: WIDTH=8, DIV=4, PARITY=0, DATA=0xA5. TX sequence per 4 cycles is 0,1,0,1,0,0,1,0,1,1, 40 cycles total, and READY=1 after the stop bit.
- Parity: PARITY=1, DATA=0x07. The parity bit is 1 and appears between bit 7 and the stop bit; the frame is 44 cycles.
- Back-to-back: VALID held, DATA=0x00 then 0xFF. The second start bit falls exactly 41 cycles after the first, and DATA changes during the frame do not corrupt it.
- Ignore while busy: a VALID pulse with DATA=0x3C mid-frame is not transmitted, and READY stays 0.
- Reset mid-frame: R pulsed during data bit 3. TX=1 asynchronously; after release a new DATA=0x81 frame is sent correctly with DIV=1 (10 cycles).

Source files
------------

// File: rtl/serial_tx_pkg.sv
// Shared definitions for the single-wire serial link: state encoding and
// default frame geometry, common to the transmitter and the future receiver.
package serial_tx_pkg;

    localparam int DEFAULT_WIDTH = 8;
    localparam int DEFAULT_DIV   = 4;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_PAR   = 3'd3,
        ST_STOP  = 3'd4
    } tx_state_t;

endpackage

// File: rtl/bit_timer.sv
// Serial bit timer: down-counter reloaded with DIV-1 at every bit boundary,
// flagging end_of_bit when it reaches zero. Shared by transmitter and receiver.
module bit_timer #(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    output logic end_of_bit
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] RELOAD = CW'(DIV - 1);

    logic [CW-1:0] count;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of its neighbours.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= RELOAD;
        end else if (count != '0) begin
            count <= count - CW'(1);
        end
    end

    // With DIV=1 the reload value is 0, so every cycle ends a bit.
    assign end_of_bit = (count == '0);

endmodule

// File: rtl/serial_tx.sv
// Asynchronous-serial frame transmitter: start bit, WIDTH data bits LSB-first,
// optional even parity bit, stop bit. All outputs come straight from flops.
module serial_tx
    import serial_tx_pkg::*;
#(
    parameter int WIDTH  = DEFAULT_WIDTH,
    parameter int DIV    = DEFAULT_DIV,
    parameter int PARITY = 0
) (
    input  logic             C,
    input  logic             R,
    input  logic [WIDTH-1:0] DATA,
    input  logic             VALID,
    output logic             READY,
    output logic             TX,
    output logic             BUSY
);

    localparam int BCW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [BCW-1:0] LAST_BIT = BCW'(WIDTH - 1);

    tx_state_t        state_q, state_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [BCW-1:0]   bit_cnt_q, bit_cnt_d;
    logic             par_q, par_d;
    logic             tx_q, tx_d;
    logic             ready_q, busy_q;
    logic             timer_load;
    logic             end_of_bit;

    bit_timer #(.DIV(DIV)) u_bit_timer (
        .clk        (C),
        .rst        (R),
        .load       (timer_load),
        .end_of_bit (end_of_bit)
    );

    always_ff @(posedge C or posedge R) begin
        if (R) begin
            state_q   <= ST_IDLE;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            par_q     <= 1'b0;
            tx_q      <= 1'b1;
            ready_q   <= 1'b1;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            par_q     <= par_d;
            tx_q      <= tx_d;
            ready_q   <= (state_d == ST_IDLE);
            busy_q    <= (state_d != ST_IDLE);
        end
    end

    // NOTE: every variable gets its hold value first, so no path through the
    // case below can leave one unassigned and infer a latch.
    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        bit_cnt_d  = bit_cnt_q;
        par_d      = par_q;
        timer_load = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (VALID && ready_q) begin
                    state_d    = ST_START;
                    shift_d    = DATA;
                    par_d      = (PARITY != 0) ? ^DATA : 1'b0;
                    timer_load = 1'b1;
                end
            end
            ST_START: begin
                if (end_of_bit) begin
                    state_d    = ST_DATA;
                    bit_cnt_d  = '0;
                    timer_load = 1'b1;
                end
            end
            ST_DATA: begin
                if (end_of_bit) begin
                    shift_d    = shift_q >> 1;
                    timer_load = 1'b1;
                    if (bit_cnt_q == LAST_BIT) begin
                        state_d = (PARITY != 0) ? ST_PAR : ST_STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + BCW'(1);
                    end
                end
            end
            ST_PAR: begin
                if (end_of_bit) begin
                    state_d    = ST_STOP;
                    timer_load = 1'b1;
                end
            end
            ST_STOP: begin
                if (end_of_bit) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Line level is derived from the next state so TX is itself a register.
    always_comb begin
        tx_d = 1'b1;
        case (state_d)
            ST_START: tx_d = 1'b0;
            ST_DATA:  tx_d = shift_d[0];
            ST_PAR:   tx_d = par_d;
            default:  tx_d = 1'b1;
        endcase
    end

    assign TX    = tx_q;
    assign READY = ready_q;
    assign BUSY  = busy_q;

endmodule

// File: tb/tb_serial_tx.sv
// Directed bench for serial_tx: three instances cover DIV=4 without parity,
// DIV=4 with even parity, and DIV=1, sharing one clock and one reset.
module tb_serial_tx;

    logic       C = 1'b0;
    logic       R = 1'b1;

    logic       valid_a = 1'b0, valid_p = 1'b0, valid_f = 1'b0;
    logic [7:0] data_a = 8'h00, data_p = 8'h00, data_f = 8'h00;
    logic       ready_a, ready_p, ready_f;
    logic       tx_a, tx_p, tx_f;
    logic       busy_a, busy_p, busy_f;

    int vectors = 0;
    int miscompares = 0;

    always #5 C = ~C;

    serial_tx #(.WIDTH(8), .DIV(4), .PARITY(0)) u_a (
        .C(C), .R(R), .DATA(data_a), .VALID(valid_a),
        .READY(ready_a), .TX(tx_a), .BUSY(busy_a)
    );

    serial_tx #(.WIDTH(8), .DIV(4), .PARITY(1)) u_p (
        .C(C), .R(R), .DATA(data_p), .VALID(valid_p),
        .READY(ready_p), .TX(tx_p), .BUSY(busy_p)
    );

    serial_tx #(.WIDTH(8), .DIV(1), .PARITY(0)) u_f (
        .C(C), .R(R), .DATA(data_f), .VALID(valid_f),
        .READY(ready_f), .TX(tx_f), .BUSY(busy_f)
    );

    task automatic tick();
        @(posedge C);
        #1;
    endtask

    task automatic test_reset();
        repeat (3) tick();
        #2;
        R = 1'b1;
        #1;
        vectors++;
        if ({tx_a, ready_a, busy_a} !== 3'b110) begin
            miscompares++;
            $display("FAIL reset_async_a: tx/ready/busy=%b expected 110", {tx_a, ready_a, busy_a});
        end
        vectors++;
        if ({tx_p, ready_p, busy_p, tx_f, ready_f, busy_f} !== 6'b110110) begin
            miscompares++;
            $display("FAIL reset_async_pf: got %b expected 110110",
                     {tx_p, ready_p, busy_p, tx_f, ready_f, busy_f});
        end
        tick();
        R = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            vectors++;
            if ({tx_a, ready_a, busy_a, tx_f} !== 4'b1101) begin
                miscompares++;
                $display("FAIL reset_idle cycle %0d: tx_a/ready_a/busy_a/tx_f=%b expected 1101",
                         i, {tx_a, ready_a, busy_a, tx_f});
            end
        end
    endtask

    task automatic test_single_frame();
        logic [9:0] exp_bits;
        exp_bits = 10'b1101001010;  // stop, 0xA5, start
        data_a  = 8'hA5;
        valid_a = 1'b1;
        tick();
        valid_a = 1'b0;
        data_a  = 8'h00;
        for (int c = 0; c < 40; c++) begin
            vectors++;
            if ({tx_a, ready_a, busy_a} !== {exp_bits[c / 4], 2'b01}) begin
                miscompares++;
                $display("FAIL single_frame cycle %0d: tx/ready/busy=%b expected %b",
                         c, {tx_a, ready_a, busy_a}, {exp_bits[c / 4], 2'b01});
            end
            tick();
        end
        vectors++;
        if ({tx_a, ready_a, busy_a} !== 3'b110) begin
            miscompares++;
            $display("FAIL single_frame_end: tx/ready/busy=%b expected 110", {tx_a, ready_a, busy_a});
        end
    endtask

    task automatic test_parity();
        logic [10:0] exp_bits;
        exp_bits = 11'b11000001110;  // stop, parity=1, 0x07, start
        data_p  = 8'h07;
        valid_p = 1'b1;
        tick();
        valid_p = 1'b0;
        data_p  = 8'hFE;
        for (int c = 0; c < 44; c++) begin
            vectors++;
            if ({tx_p, busy_p} !== {exp_bits[c / 4], 1'b1}) begin
                miscompares++;
                $display("FAIL parity_frame cycle %0d: tx/busy=%b expected %b",
                         c, {tx_p, busy_p}, {exp_bits[c / 4], 1'b1});
            end
            tick();
        end
        vectors++;
        if ({tx_p, ready_p, busy_p} !== 3'b110) begin
            miscompares++;
            $display("FAIL parity_end: tx/ready/busy=%b expected 110 at cycle 44", {tx_p, ready_p, busy_p});
        end
    endtask

    task automatic test_back_to_back();
        logic [9:0] exp_first;
        logic [9:0] exp_second;
        exp_first  = 10'b1000000000;
        exp_second = 10'b1111111110;
        data_a  = 8'h00;
        valid_a = 1'b1;
        tick();
        data_a = 8'hFF;
        for (int c = 0; c < 40; c++) begin
            vectors++;
            if (tx_a !== exp_first[c / 4]) begin
                miscompares++;
                $display("FAIL b2b_first cycle %0d: tx=%b expected %b", c, tx_a, exp_first[c / 4]);
            end
            tick();
        end
        vectors++;
        if ({tx_a, ready_a} !== 2'b11) begin
            miscompares++;
            $display("FAIL b2b_gap: tx/ready=%b expected 11", {tx_a, ready_a});
        end
        tick();
        valid_a = 1'b0;
        data_a  = 8'h5A;
        for (int c = 0; c < 40; c++) begin
            vectors++;
            if (tx_a !== exp_second[c / 4]) begin
                miscompares++;
                $display("FAIL b2b_second cycle %0d (41+%0d after first start): tx=%b expected %b",
                         c, c, tx_a, exp_second[c / 4]);
            end
            tick();
        end
        vectors++;
        if ({tx_a, ready_a, busy_a} !== 3'b110) begin
            miscompares++;
            $display("FAIL b2b_end: tx/ready/busy=%b expected 110", {tx_a, ready_a, busy_a});
        end
    endtask

    task automatic test_ignore_busy();
        logic [9:0] exp_bits;
        exp_bits = 10'b1010110100;  // stop, 0x5A, start
        data_a  = 8'h5A;
        valid_a = 1'b1;
        tick();
        valid_a = 1'b0;
        for (int c = 0; c < 40; c++) begin
            if (c == 12) begin
                data_a  = 8'h3C;
                valid_a = 1'b1;
            end else if (c == 13) begin
                valid_a = 1'b0;
                data_a  = 8'h00;
            end
            vectors++;
            if ({tx_a, ready_a} !== {exp_bits[c / 4], 1'b0}) begin
                miscompares++;
                $display("FAIL ignore_busy cycle %0d: tx/ready=%b expected %b",
                         c, {tx_a, ready_a}, {exp_bits[c / 4], 1'b0});
            end
            tick();
        end
        for (int c = 0; c < 16; c++) begin
            vectors++;
            if ({tx_a, ready_a, busy_a} !== 3'b110) begin
                miscompares++;
                $display("FAIL ignore_busy_after cycle %0d: tx/ready/busy=%b expected 110",
                         c, {tx_a, ready_a, busy_a});
            end
            tick();
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [9:0] exp_bits;
        exp_bits = 10'b1100000010;  // stop, 0x81, start
        data_f  = 8'h00;
        valid_f = 1'b1;
        tick();
        valid_f = 1'b0;
        repeat (4) tick();
        vectors++;
        if ({tx_f, busy_f} !== 2'b01) begin
            miscompares++;
            $display("FAIL midframe_bit3: tx/busy=%b expected 01", {tx_f, busy_f});
        end
        #2;
        R = 1'b1;
        #1;
        vectors++;
        if ({tx_f, ready_f, busy_f} !== 3'b110) begin
            miscompares++;
            $display("FAIL midframe_async: tx/ready/busy=%b expected 110", {tx_f, ready_f, busy_f});
        end
        tick();
        R = 1'b0;
        tick();
        vectors++;
        if ({tx_f, ready_f, busy_f} !== 3'b110) begin
            miscompares++;
            $display("FAIL midframe_release: tx/ready/busy=%b expected 110", {tx_f, ready_f, busy_f});
        end
        data_f  = 8'h81;
        valid_f = 1'b1;
        tick();
        valid_f = 1'b0;
        data_f  = 8'h00;
        for (int c = 0; c < 10; c++) begin
            vectors++;
            if ({tx_f, busy_f} !== {exp_bits[c], 1'b1}) begin
                miscompares++;
                $display("FAIL div1_frame cycle %0d: tx/busy=%b expected %b",
                         c, {tx_f, busy_f}, {exp_bits[c], 1'b1});
            end
            tick();
        end
        vectors++;
        if ({tx_f, ready_f, busy_f} !== 3'b110) begin
            miscompares++;
            $display("FAIL div1_end: tx/ready/busy=%b expected 110", {tx_f, ready_f, busy_f});
        end
    endtask

    initial begin
        #3;
        tick();
        R = 1'b0;
        tick();
        test_reset();
        test_single_frame();
        test_parity();
        test_back_to_back();
        test_ignore_busy();
        test_reset_mid_frame();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

endmodule
